// File: rtl/graduation_list_mc_if.sv
// Shared instruction types for the graduation list and the bundle of
// dispatch, writeback, flush and commit signals that connect to it.
package graduation_list_mc_pkg;

  typedef enum logic [3:0] {
    ADD      = 4'd0,
    SUB      = 4'd1,
    LD       = 4'd2,
    SD       = 4'd3,
    SW       = 4'd4,
    SH       = 4'd5,
    SB       = 4'd6,
    VSE      = 4'd7,
    VLE      = 4'd8,
    AMO_ADD  = 4'd9,
    AMO_SWAP = 4'd10,
    AMO_AND  = 4'd11,
    AMO_OR   = 4'd12,
    CSRRW    = 4'd13,
    FENCE    = 4'd14,
    BEQ      = 4'd15
  } instr_type_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } exception_t;

  typedef struct packed {
    logic        valid;
    instr_type_t instr_type;
    logic [31:0] pc;
    exception_t  exception;
    logic        stall_csr_fence;
    logic [11:0] csr_addr;
    logic [31:0] result;
    logic [5:0]  old_prd;
    logic [5:0]  old_pvd;
  } gl_instruction_t;

  // Stores and AMOs have nothing to write back, so they are finished on entry.
  function automatic logic ready_on_insert(instr_type_t t);
    case (t)
      SD, SW, SH, SB, VSE, AMO_ADD, AMO_SWAP, AMO_AND, AMO_OR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

interface graduation_list_mc_if #(
  parameter int unsigned NUM_ENTRIES   = 32,
  parameter int unsigned COMMIT_WIDTH  = 2,
  parameter int unsigned NUM_SCALAR_WB = 2,
  parameter int unsigned NUM_SIMD_WB   = 1
) ();
  import graduation_list_mc_pkg::*;

  localparam int unsigned NUM_WB = NUM_SCALAR_WB + NUM_SIMD_WB;
  localparam int unsigned IDX_W  = $clog2(NUM_ENTRIES);

  gl_instruction_t   instruction_i;
  logic              read_head_i;
  logic [IDX_W-1:0]  wb_index_i [NUM_WB];
  logic [NUM_WB-1:0] wb_enable_i;
  gl_instruction_t   wb_data_i [NUM_WB];
  logic              flush_i;
  logic [IDX_W-1:0]  flush_index_i;
  logic              flush_commit_i;
  logic [IDX_W-1:0]  assigned_gl_entry_o;
  gl_instruction_t   instruction_o [COMMIT_WIDTH];
  logic [IDX_W-1:0]  commit_gl_entry_o [COMMIT_WIDTH];
  logic              full_o;
  logic              empty_o;

  modport master (
    output instruction_i, read_head_i, wb_index_i, wb_enable_i, wb_data_i,
           flush_i, flush_index_i, flush_commit_i,
    input  assigned_gl_entry_o, instruction_o, commit_gl_entry_o, full_o, empty_o
  );

  modport slave (
    input  instruction_i, read_head_i, wb_index_i, wb_enable_i, wb_data_i,
           flush_i, flush_index_i, flush_commit_i,
    output assigned_gl_entry_o, instruction_o, commit_gl_entry_o, full_o, empty_o
  );

endinterface

// File: rtl/graduation_list_mc.sv
// Multi-commit reorder buffer: tracks in-flight instructions in program order
// and retires up to COMMIT_WIDTH finished ones per cycle, serialising exceptions.
module graduation_list_mc
  import graduation_list_mc_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES   = 32,
  parameter int unsigned COMMIT_WIDTH  = 2,
  parameter int unsigned NUM_SCALAR_WB = 2,
  parameter int unsigned NUM_SIMD_WB   = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  graduation_list_mc_if.slave gl
);

  localparam int unsigned NUM_WB = NUM_SCALAR_WB + NUM_SIMD_WB;
  localparam int unsigned IDX_W  = $clog2(NUM_ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   ptr_t;

  ptr_t                    head;
  ptr_t                    tail;
  ptr_t                    count;
  ptr_t                    flush_count;
  ptr_t                    retire_cnt;
  idx_t                    flush_dist;
  idx_t                    slot_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] retire;
  logic [NUM_ENTRIES-1:0]  ready;
  gl_instruction_t         entries [NUM_ENTRIES];
  logic                    insert;
  logic                    do_flush;
  logic                    unused_wb_fields;

  assign count                  = tail - head;
  assign gl.full_o              = (count == ptr_t'(NUM_ENTRIES));
  assign gl.empty_o             = (count == '0);
  assign gl.assigned_gl_entry_o = tail[IDX_W-1:0];

  assign insert   = gl.instruction_i.valid & ~gl.full_o & ~gl.flush_i & ~gl.flush_commit_i;
  assign do_flush = gl.flush_i & ~gl.empty_o & ~gl.flush_commit_i;

  // Distance is taken modulo NUM_ENTRIES first; adding it to head then lands
  // the new tail on flush_index+1 with the correct wrap bit.
  assign flush_dist  = gl.flush_index_i - head[IDX_W-1:0];
  assign flush_count = {1'b0, flush_dist} + ptr_t'(1);

  always_comb begin
    logic prev_ok;
    logic blocked;
    logic serial;
    logic can;
    retire     = '0;
    retire_cnt = '0;
    prev_ok    = 1'b1;
    blocked    = 1'b0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx[k] = head[IDX_W-1:0] + idx_t'(k);
      serial = entries[slot_idx[k]].exception.valid | entries[slot_idx[k]].stall_csr_fence;
      can    = gl.read_head_i & ~gl.flush_i & ~gl.flush_commit_i
             & (ptr_t'(k) < count) & ready[slot_idx[k]];
      // Slot 0 may carry a serialising instruction; it then retires alone.
      retire[k] = can & prev_ok & ((k == 0) || (!blocked && !serial));
      blocked   = blocked | serial;
      prev_ok   = retire[k];
      if (retire[k]) retire_cnt = retire_cnt + ptr_t'(1);
    end
  end

  always_comb begin
    unused_wb_fields = 1'b0;
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      unused_wb_fields = unused_wb_fields ^ (^{gl.wb_data_i[p].valid, gl.wb_data_i[p].instr_type,
                         gl.wb_data_i[p].pc, gl.wb_data_i[p].stall_csr_fence,
                         gl.wb_data_i[p].old_prd, gl.wb_data_i[p].old_pvd});
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      ready <= '0;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        gl.instruction_o[k]     <= '0;
        gl.commit_gl_entry_o[k] <= '0;
      end
    end else if (gl.flush_commit_i) begin
      head  <= '0;
      tail  <= '0;
      ready <= '0;
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        gl.instruction_o[k]     <= '0;
        gl.commit_gl_entry_o[k] <= '0;
      end
    end else begin
      if (do_flush) begin
        tail <= head + flush_count;
      end else begin
        head <= head + retire_cnt;
        if (insert) tail <= tail + ptr_t'(1);
      end
      for (int unsigned p = 0; p < NUM_WB; p++) begin
        if (gl.wb_enable_i[p]) ready[gl.wb_index_i[p]] <= 1'b1;
      end
      if (insert) ready[tail[IDX_W-1:0]] <= ready_on_insert(gl.instruction_i.instr_type);
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (retire[k]) begin
          gl.instruction_o[k]     <= entries[slot_idx[k]];
          gl.commit_gl_entry_o[k] <= slot_idx[k];
        end else begin
          gl.instruction_o[k]     <= '0;
          gl.commit_gl_entry_o[k] <= '0;
        end
      end
    end
  end

  // Payload storage needs no reset: liveness is carried by the pointers.
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      if (gl.wb_enable_i[p]) begin
        entries[gl.wb_index_i[p]].csr_addr  <= gl.wb_data_i[p].csr_addr;
        entries[gl.wb_index_i[p]].exception <= gl.wb_data_i[p].exception;
        entries[gl.wb_index_i[p]].result    <= gl.wb_data_i[p].result;
      end
    end
    if (insert) entries[tail[IDX_W-1:0]] <= gl.instruction_i;
  end

endmodule

// File: doc/graduation_list_mc.md
# graduation_list_mc

Multi-commit, parametrised reorder buffer for the writeback/commit stage. It sits between rename/dispatch and the commit logic. It tracks every in-flight instruction in program order and takes completion marks from any number of scalar and SIMD writeback ports. It retires up to COMMIT_WIDTH finished instructions per cycle, in order. Exception and CSR/fence-stalling instructions retire alone, so commit-side serialisation stays trivial.

## Interface
Parameters:
- NUM_ENTRIES, 32: entries; power of two, ≥4.
- COMMIT_WIDTH, 2: max retirements per cycle, 1..4.
- NUM_WB, NUM_SCALAR_WB + NUM_SIMD_WB: total writeback ports; port order has no priority meaning.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- instruction_i  in  gl_instruction_t  dispatched instruction; .valid requests insertion.
- read_head_i  in  1  commit stage accepts retirements this cycle.
- wb_index_i  in  NUM_WB×gl_index_t  entry to mark finished.
- wb_enable_i  in  NUM_WB  per-port write enable.
- wb_data_i  in  NUM_WB×gl_instruction_t  source of csr_addr, exception and result.
- flush_i  in  1  discard all entries younger than flush_index_i.
- flush_index_i  in  gl_index_t  youngest surviving entry.
- flush_commit_i  in  1  discard everything.
- assigned_gl_entry_o  out  gl_index_t  index given to instruction_i (current tail).
- instruction_o  out  COMMIT_WIDTH×gl_instruction_t  retired instructions; slot 0 oldest.
- commit_gl_entry_o  out  COMMIT_WIDTH×gl_index_t  index of each retired slot.
- full_o  out  1  count == NUM_ENTRIES.
- empty_o  out  1  count == 0.

## Operation
- Head and tail are index-width+1 pointers; the MSB is the wrap bit.
  - count = tail − head, modulo 2^(w+1).
  - No entry is sacrificed; full means all NUM_ENTRIES are occupied.
- Insertion:
  - Condition: instruction_i.valid & ~full_o & ~flush_i & ~flush_commit_i.
  - The entry is written at tail and tail increments.
  - The ready bit initialises to 1 for SD/SW/SH/SB/VSE and all AMO_* types, and to 0 otherwise.
- Writeback: each enabled port sets ready[wb_index] and overwrites csr_addr, exception and result at that index.
  - Two ports targeting the same index in one cycle is illegal; the higher port number wins.
  - Writeback to a non-live index is harmless, because a later insertion reinitialises the entry.
- Retirement window: slots k = 0..COMMIT_WIDTH-1 at head+k. Slot k retires iff all of the following hold:
  - read_head_i is high, and flush_i and flush_commit_i are low.
  - k < count.
  - ready[head+k] is set.
  - Every slot j<k retires.
  - Neither slot k nor any slot j<k has exception.valid or stall_csr_fence. Slot 0 is exempt, so such an instruction retires only as slot 0, alone.
  - head advances by the number of retired slots, R.
- Flush (flush_i & count>0):
  - tail ← flush_index_i+1, with the wrap bit chosen so that new count = ((flush_index_i − head) mod NUM_ENTRIES) + 1.
  - No retirement or insertion occurs that cycle.
  - flush_i with count==0 is ignored.
- flush_commit_i has priority over flush_i: head ← 0, tail ← 0, all ready bits cleared, no retirement.
- Simultaneous insert and retire: count += 1 − R.

## Timing
- Reset:
  - head = tail = 0 and all ready bits are 0.
  - instruction_o[*].valid = 0, .exception.valid = 0, .stall_csr_fence = 0, .instr_type = ADD, .old_prd = .old_pvd = 0.
  - commit_gl_entry_o = 0, empty_o = 1, full_o = 0, assigned_gl_entry_o = 0.
- instruction_o and commit_gl_entry_o are registered.
  - Retirement decided in cycle N appears after edge N, with 1-cycle latency.
  - Non-retiring slots drive the reset values above.
- Readiness latency:
  - Insert at edge N makes the entry retire-eligible in cycle N+1 if it is a store/AMO.
  - Writeback at edge N makes the entry eligible in cycle N+1; there is no same-cycle bypass.
- full_o, empty_o and assigned_gl_entry_o are combinational from the registered pointers.
- Pointer wrap is seamless: the window may straddle index NUM_ENTRIES-1 → 0.

## Test plan
Scenarios use NUM_ENTRIES=8 and COMMIT_WIDTH=2.
- Reset then fill: insert 8 ADDs → assigned indices 0..7; full_o=1 after the 8th; a 9th insert is dropped with no pointer change.
- Dual retire: entries 0,1 written back in one cycle, read_head_i=1 → next cycle instruction_o[0,1].valid=1 with commit_gl_entry_o={0,1}; count drops by 2.
- Exception serialisation:
  - Entry 2 is ready with no exception; entry 3 is ready with exception.valid.
  - Cycle 1 retires only entry 2; cycle 2 retires entry 3 alone in slot 0.
- Wrap: with head=7 and entries 7,0 ready → both retire in one cycle; head becomes index 1 with the wrap bit toggled.
- Partial flush: head=6, tail=3 (count 5), flush_index_i=0 → tail=1, count=3, no retirement that cycle; the next insert gets index 1.
- flush_commit_i asserted together with flush_i and a valid insert → head=tail=0, empty_o=1, nothing inserted or retired. Asserting rst_i mid-stream returns every output to its reset value immediately, without waiting for a clock edge.
